// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and width helper for the ripple-carry adder unit.
package adder_pkg;
    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    function automatic int sum_width(input int w);
        return w + 1;
    endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit full adder, the repeating cell of the ripple chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/adder_unit.sv
// adder_unit: ripple-carry adder with combinational sum, registered copy and saturating carry counter.
module adder_unit
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   y,
    output logic [WIDTH:0]   y_q,
    output logic             cout_q,
    output logic [CNT_W-1:0] carry_cnt
);
    localparam int SW = sum_width(WIDTH);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic [SW-1:0]    y_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder_cell u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    assign y_d = {c[WIDTH], s};
    assign y   = y_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            cout_q <= y_d[SW-1];
        end
    end

    // Counter holds at all-ones so it never wraps back to zero.
    assign cnt_d = (y_d[SW-1] && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign carry_cnt = cnt_q;
endmodule

// File: tb/tb_adder_unit.sv
// tb_adder_unit: randomized and directed checks of adder_unit against an arithmetic reference model.
module tb_adder_unit;
    localparam int W   = 4;
    localparam int CW  = 8;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W:0]    y, y_q;
    logic          cout_q;
    logic [CW-1:0] carry_cnt;

    int vecs = 0;
    int errs = 0;
    int m_yq = 0;
    int m_cnt = 0;

    adder_unit #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .y        (y),
        .y_q      (y_q),
        .cout_q   (cout_q),
        .carry_cnt(carry_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: advances on a rising edge using plain integer arithmetic.
    task automatic tick();
        int sum;
        @(posedge clk);
        sum = int'(a) + int'(b);
        if (rst) begin
            m_yq  = 0;
            m_cnt = 0;
        end else begin
            m_yq = sum;
            if (sum >= (1 << W) && m_cnt < MAXC) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++;
        if (y_q !== 5'd0 || cout_q !== 1'b0 || carry_cnt !== 8'd0) begin
            errs++;
            $display("FAIL reset: y_q=%0d cout_q=%b cnt=%0d want 0 0 0", y_q, cout_q, carry_cnt);
        end
    endtask

    task automatic test_zero();
        logic [W:0] ops[2][2];
        ops[0] = '{5'd0, 5'd0};
        ops[1] = '{5'd5, 5'd0};
        for (int i = 0; i < 2; i++) begin
            a = ops[i][0][W-1:0];
            b = ops[i][1][W-1:0];
            #1;
            vecs++;
            if (y !== int'(a) + int'(b)) begin
                errs++;
                $display("FAIL zero_y: got %0d want %0d", y, int'(a) + int'(b));
            end
            tick();
            vecs++;
            if (y_q !== m_yq[W:0] || carry_cnt !== 8'd0) begin
                errs++;
                $display("FAIL zero_reg: y_q=%0d cnt=%0d want %0d 0", y_q, carry_cnt, m_yq);
            end
        end
    endtask

    task automatic test_max();
        a = 4'd15;
        b = 4'd15;
        #1;
        vecs++;
        if (y !== 5'b11110) begin
            errs++;
            $display("FAIL max_y: got %0d want 30", y);
        end
        tick();
        vecs++;
        if (y_q !== 5'd30 || cout_q !== 1'b1 || carry_cnt !== 8'd1) begin
            errs++;
            $display("FAIL max_reg: y_q=%0d cout_q=%b cnt=%0d want 30 1 1", y_q, cout_q, carry_cnt);
        end
    endtask

    task automatic test_carry_boundary();
        a = 4'd9;
        b = 4'd7;
        #1;
        vecs++;
        if (y !== 5'd16 || y[W] !== 1'b1) begin
            errs++;
            $display("FAIL bnd_16: got %0d want 16", y);
        end
        tick();
        a = 4'd8;
        b = 4'd7;
        #1;
        vecs++;
        if (y !== 5'd15 || y[W] !== 1'b0 || y_q !== 5'd16) begin
            errs++;
            $display("FAIL bnd_15: y=%0d y_q=%0d want 15 16", y, y_q);
        end
        tick();
        vecs++;
        if (y_q !== 5'd15 || cout_q !== 1'b0 || carry_cnt !== m_cnt[CW-1:0]) begin
            errs++;
            $display("FAIL bnd_lag: y_q=%0d cout_q=%b cnt=%0d want 15 0 %0d", y_q, cout_q, carry_cnt, m_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 15; i++) begin
            a = W'($urandom_range(0, (1 << W) - 1));
            b = W'($urandom_range(0, (1 << W) - 1));
            #1;
            vecs++;
            if (y !== int'(a) + int'(b)) begin
                errs++;
                $display("FAIL rand_y[%0d]: a=%0d b=%0d got %0d want %0d", i, a, b, y, int'(a) + int'(b));
            end
            for (int k = 0; k < 2; k++) begin
                tick();
                vecs++;
                if (y_q !== m_yq[W:0] || cout_q !== (m_yq >= (1 << W)) || carry_cnt !== m_cnt[CW-1:0]) begin
                    errs++;
                    $display("FAIL rand_reg[%0d]: y_q=%0d cout_q=%b cnt=%0d want %0d %0d", i, y_q, cout_q, carry_cnt, m_yq, m_cnt);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a = 4'd12;
        b = 4'd6;
        repeat (3) tick();
        vecs++;
        if (carry_cnt !== 8'd3) begin
            errs++;
            $display("FAIL mid_pre: cnt=%0d want 3", carry_cnt);
        end
        rst = 1'b1;
        tick();
        vecs++;
        if (y_q !== 5'd0 || cout_q !== 1'b0 || carry_cnt !== 8'd0 || y !== 5'd18) begin
            errs++;
            $display("FAIL mid_rst: y_q=%0d cout_q=%b cnt=%0d y=%0d want 0 0 0 18", y_q, cout_q, carry_cnt, y);
        end
        rst = 1'b0;
        tick();
        vecs++;
        if (y_q !== 5'd18 || cout_q !== 1'b1 || carry_cnt !== 8'd1) begin
            errs++;
            $display("FAIL mid_resume: y_q=%0d cout_q=%b cnt=%0d want 18 1 1", y_q, cout_q, carry_cnt);
        end
    endtask

    task automatic test_saturation();
        int bad = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a = 4'd15;
        b = 4'd1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            vecs++;
            if (carry_cnt !== m_cnt[CW-1:0] || y_q !== 5'd16) begin
                errs++;
                if (bad++ < 5) $display("FAIL sat_step[%0d]: cnt=%0d y_q=%0d want %0d 16", n, carry_cnt, y_q, m_cnt);
            end
        end
        vecs++;
        if (carry_cnt !== 8'd255) begin
            errs++;
            $display("FAIL sat_final: cnt=%0d want 255", carry_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max();
        test_carry_boundary();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
